// File: rtl/fpu_share_ctrl.sv
// Shares one fpu between NREQ requesters: round-robin arbitration, act/done
// sequencing with timeout, and idle-driven adder power gating.
module fpu_share_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned IDLE_PD     = 16,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter logic [7:0]  ADD_MASK    = 8'b0000_0011
) (
  input  logic                  clk,
  input  logic                  rstp,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0]     req_rm,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic [5:0]            resp_flags,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      fpu_in1,
  output logic [WIDTH-1:0]      fpu_in2,
  output logic [2:0]            fpu_opcode,
  output logic [2:0]            fpu_round_m,
  output logic                  fpu_act,
  input  logic                  fpu_done,
  input  logic [WIDTH-1:0]      fpu_out,
  input  logic                  fpu_inv,
  input  logic                  fpu_ov,
  input  logic                  fpu_un,
  input  logic                  fpu_eq,
  input  logic                  fpu_great,
  input  logic                  fpu_less,
  output logic                  fpu_enable_add,
  output logic                  fpu_power_off_add,
  output logic                  fpu_retain_add
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = $clog2(IDLE_PD + 1);
  localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAKE, S_ARM, S_RUN, S_RESP} state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     cur;
  logic [IW-1:0]     win;
  logic              found;
  int unsigned       idx;
  logic [2:0]        win_op;
  logic [2:0]        win_rm;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic              win_add;
  logic              cur_add;
  logic              accept;
  logic [TW-1:0]     run_cnt;
  logic [WW-1:0]     wake_cnt;
  logic [CW-1:0]     idle_cnt;
  logic [CW-1:0]     idle_nxt;
  logic              idle_inc;
  logic              pwr_down;

  // First requesting index at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_op  = req_op[3*win +: 3];
  assign win_rm  = req_rm[3*win +: 3];
  assign win_a   = req_a[WIDTH*win +: WIDTH];
  assign win_b   = req_b[WIDTH*win +: WIDTH];
  assign win_add = ADD_MASK[win_op];
  assign accept  = (state == S_IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Counter saturates at IDLE_PD; only an accepted adder-class op clears it.
  always_comb begin
    idle_inc = 1'b0;
    case (state)
      S_IDLE:  idle_inc = !(found && win_add);
      S_RESP:  idle_inc = 1'b1;
      default: idle_inc = !cur_add;
    endcase
    if (accept && win_add)
      idle_nxt = '0;
    else if (idle_inc && idle_cnt != CW'(IDLE_PD))
      idle_nxt = idle_cnt + 1'b1;
    else
      idle_nxt = idle_cnt;
    pwr_down = (idle_nxt == CW'(IDLE_PD)) && fpu_enable_add && !accept;
  end

  assign fpu_retain_add = 1'b1;

  always_ff @(posedge clk) begin
    if (!rstp) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      cur               <= '0;
      cur_add           <= 1'b0;
      run_cnt           <= '0;
      wake_cnt          <= '0;
      idle_cnt          <= '0;
      resp_valid        <= '0;
      resp_data         <= '0;
      resp_flags        <= '0;
      resp_err          <= 1'b0;
      fpu_in1           <= '0;
      fpu_in2           <= '0;
      fpu_opcode        <= '0;
      fpu_round_m       <= '0;
      fpu_act           <= 1'b0;
      fpu_enable_add    <= 1'b1;
      fpu_power_off_add <= 1'b0;
    end else begin
      resp_valid <= '0;
      idle_cnt   <= idle_nxt;
      if (pwr_down) begin
        fpu_enable_add    <= 1'b0;
        fpu_power_off_add <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (found) begin
            fpu_in1     <= win_a;
            fpu_in2     <= win_b;
            fpu_opcode  <= win_op;
            fpu_round_m <= win_rm;
            cur         <= win;
            cur_add     <= win_add;
            rr_ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            if (win_add && !fpu_enable_add) begin
              fpu_power_off_add <= 1'b0;
              wake_cnt          <= '0;
              state             <= S_WAKE;
            end else begin
              state <= S_ARM;
            end
          end
        end
        S_WAKE: begin
          if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
            fpu_enable_add <= 1'b1;
            state          <= S_ARM;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        S_ARM: begin
          fpu_act <= 1'b1;
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          // A done seen on the first RUN cycle may be left over from a prior op.
          if (run_cnt != '0 && fpu_done) begin
            resp_data       <= fpu_out;
            resp_flags      <= {fpu_inv, fpu_ov, fpu_un, fpu_eq, fpu_great, fpu_less};
            resp_err        <= 1'b0;
            resp_valid[cur] <= 1'b1;
            fpu_act         <= 1'b0;
            state           <= S_RESP;
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            resp_data       <= '0;
            resp_flags      <= '0;
            resp_err        <= 1'b1;
            resp_valid[cur] <= 1'b1;
            fpu_act         <= 1'b0;
            state           <= S_RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Scoreboard bench for fpu_share_ctrl with a behavioural fpu handshake model.
module tb_fpu_share_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rstp = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_a = '0;
  logic [WIDTH*NREQ-1:0] req_b = '0;
  logic [3*NREQ-1:0]     req_rm = '0;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic [5:0]            resp_flags;
  logic                  resp_err;
  logic [WIDTH-1:0]      fpu_in1, fpu_in2;
  logic [2:0]            fpu_opcode, fpu_round_m;
  logic                  fpu_act;
  logic                  fpu_done = 1'b0;
  logic [WIDTH-1:0]      fpu_out = '0;
  logic                  fpu_inv = 1'b0, fpu_ov = 1'b0, fpu_un = 1'b0;
  logic                  fpu_eq = 1'b0, fpu_great = 1'b0, fpu_less = 1'b0;
  logic                  fpu_enable_add, fpu_power_off_add, fpu_retain_add;

  always #5 clk = ~clk;

  fpu_share_ctrl #(
    .WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDLE_PD(16),
    .WAKE_CYCLES(4), .ADD_MASK(8'b0000_0011)
  ) dut (
    .clk(clk), .rstp(rstp),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .resp_err(resp_err),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_opcode(fpu_opcode),
    .fpu_round_m(fpu_round_m), .fpu_act(fpu_act), .fpu_done(fpu_done),
    .fpu_out(fpu_out), .fpu_inv(fpu_inv), .fpu_ov(fpu_ov), .fpu_un(fpu_un),
    .fpu_eq(fpu_eq), .fpu_great(fpu_great), .fpu_less(fpu_less),
    .fpu_enable_add(fpu_enable_add), .fpu_power_off_add(fpu_power_off_add),
    .fpu_retain_add(fpu_retain_add)
  );

  typedef struct {
    int          grant;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  rm;
    logic [31:0] data;
    logic [5:0]  flags;
    logic        err;
    int          act_lat;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // fpu model: done on RUN cycle done_delay (0 = never), or stuck high.
  logic        stale_mode  = 1'b0;
  logic        echo_b      = 1'b0;
  int          done_delay  = 3;
  logic [31:0] model_out   = '0;
  logic [5:0]  model_flags = '0;
  int          m_run       = 0;

  always @(posedge clk) begin
    #1;
    if (fpu_act === 1'b1) m_run = m_run + 1;
    else m_run = 0;
    fpu_done = stale_mode || (fpu_act === 1'b1 && done_delay != 0 && m_run >= done_delay);
    fpu_out  = echo_b ? fpu_in2 : model_out;
    {fpu_inv, fpu_ov, fpu_un, fpu_eq, fpu_great, fpu_less} = model_flags;
  end

  // Monitor: grant, fpu launch and response are checked against the queue head.
  int   acc_cyc = 0;
  logic act_q   = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      acc_cyc = cyc;
      if (exp_q.size() != 0) check("grant", req_ready, onehot(exp_q[0].grant));
    end
    if (fpu_act === 1'b1 && act_q !== 1'b1 && exp_q.size() != 0) begin
      check("fpu_in1", fpu_in1, exp_q[0].a);
      check("fpu_in2", fpu_in2, exp_q[0].b);
      check("fpu_opcode", fpu_opcode, exp_q[0].op);
      check("fpu_round_m", fpu_round_m, exp_q[0].rm);
      check("act_latency", cyc - acc_cyc, exp_q[0].act_lat);
    end
    act_q = fpu_act;
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", resp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_valid", resp_valid, onehot(e.grant));
        check("resp_data", resp_data, e.data);
        check("resp_flags", resp_flags, e.flags);
        check("resp_err", resp_err, e.err);
        check("resp_latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  task automatic push(input int g, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [2:0] rm, input logic [31:0] data,
                      input logic [5:0] flags, input logic err, input int act_lat, input int lat);
    exp_t x;
    x.grant = g; x.a = a; x.b = b; x.op = op; x.rm = rm;
    x.data = data; x.flags = flags; x.err = err; x.act_lat = act_lat; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] rm);
    req_op[3*i +: 3]      = op;
    req_a[WIDTH*i +: 32]  = a;
    req_b[WIDTH*i +: 32]  = b;
    req_rm[3*i +: 3]      = rm;
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] rm);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(i, op, a, b, rm);
    req_valid[i] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_flags"}, resp_flags, 0);
    check({tag, "_fpu_act"}, fpu_act, 0);
    check({tag, "_fpu_in1"}, fpu_in1, 0);
    check({tag, "_fpu_in2"}, fpu_in2, 0);
    check({tag, "_fpu_opcode"}, fpu_opcode, 0);
    check({tag, "_fpu_round_m"}, fpu_round_m, 0);
    check({tag, "_enable_add"}, fpu_enable_add, 1);
    check({tag, "_power_off_add"}, fpu_power_off_add, 0);
    check({tag, "_retain_add"}, fpu_retain_add, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_acc;
    logic [31:0] rr_a [4];
    logic [31:0] rr_b [4];
    rr_a[0] = 32'h3F800000; rr_a[1] = 32'h40000000; rr_a[2] = 32'h40400000; rr_a[3] = 32'h40800000;
    rr_b[0] = 32'h11110001; rr_b[1] = 32'h22220002; rr_b[2] = 32'h33330003; rr_b[3] = 32'h44440004;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rstp = 1'b1;

    // Round-robin from reset: all four requesting, model echoes operand b
    echo_b = 1'b1;
    model_flags = 6'b010100;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 3'(i), rr_a[i], rr_b[i], 3'(i + 1));
      push(i, rr_a[i], rr_b[i], 3'(i), 3'(i + 1), rr_b[i], 6'b010100, 1'b0, 2, 5);
    end
    req_valid = 4'b1111;
    n_acc = 0;
    for (int k = 0; k < 200 && n_acc < 4; k++) begin
      @(negedge clk);
      if (req_ready != '0) n_acc++;
    end
    if (n_acc != 4) check("rr_accepts", n_acc, 4);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    echo_b = 1'b0;

    // Single request, done on third RUN cycle
    model_out   = 32'hBE4CCCCC;
    model_flags = 6'b000010;
    push(0, 32'h3F8CCCCD, 32'hBFA66666, 3'b000, 3'b001, 32'hBE4CCCCC, 6'b000010, 1'b0, 2, 5);
    issue(0, 3'b000, 32'h3F8CCCCD, 32'hBFA66666, 3'b001);
    drain();

    // Stale done held high: completion on second RUN cycle
    stale_mode  = 1'b1;
    model_out   = 32'h0000_ABCD;
    model_flags = 6'b001000;
    push(2, 32'h40A00000, 32'h40C00000, 3'b000, 3'b010, 32'h0000_ABCD, 6'b001000, 1'b0, 2, 4);
    issue(2, 3'b000, 32'h40A00000, 32'h40C00000, 3'b010);
    drain();
    stale_mode = 1'b0;

    // Timeout: done never arrives
    done_delay = 0;
    push(1, 32'h41000000, 32'h41100000, 3'b000, 3'b011, 32'h0, 6'b0, 1'b1, 2, TIMEOUT + 2);
    issue(1, 3'b000, 32'h41000000, 32'h41100000, 3'b011);
    drain();
    done_delay  = 3;
    model_out   = 32'h12345678;
    model_flags = 6'b100001;
    push(3, 32'h41200000, 32'h41300000, 3'b001, 3'b100, 32'h12345678, 6'b100001, 1'b0, 2, 5);
    issue(3, 3'b001, 32'h41200000, 32'h41300000, 3'b100);
    drain();

    // Reset in the middle of RUN
    done_delay = 0;
    issue(0, 3'b000, 32'h3F800000, 32'h3F800000, 3'b000);
    for (int k = 0; k < 20 && fpu_act !== 1'b1; k++) @(negedge clk);
    check("midrun_act_seen", fpu_act, 1);
    @(posedge clk); #1;
    rstp = 1'b0;
    @(posedge clk); #1;
    rstp = 1'b1;
    @(negedge clk);
    check_reset("midrun");
    done_delay = 3;

    // Idle power-down: still up after 15 idle cycles, down at 16
    repeat (15) @(negedge clk);
    check("pd_still_up", fpu_enable_add, 1);
    @(negedge clk);
    check("pd_enable_add", fpu_enable_add, 0);
    check("pd_power_off_add", fpu_power_off_add, 1);
    check("pd_retain_add", fpu_retain_add, 1);

    // Non-adder op while down: no wake
    model_out   = 32'h40490FDB;
    model_flags = 6'b000100;
    push(0, 32'h40000000, 32'h40400000, 3'b011, 3'b000, 32'h40490FDB, 6'b000100, 1'b0, 2, 5);
    issue(0, 3'b011, 32'h40000000, 32'h40400000, 3'b000);
    @(negedge clk);
    check("nonadd_power_off", fpu_power_off_add, 1);
    check("nonadd_enable", fpu_enable_add, 0);
    drain();

    // Adder op while down: wake sequence then normal run
    model_out   = 32'h439F2666;
    model_flags = 6'b000010;
    push(1, 32'h43A0CCCD, 32'hBFE66666, 3'b001, 3'b000, 32'h439F2666, 6'b000010, 1'b0, 6, 9);
    issue(1, 3'b001, 32'h43A0CCCD, 32'hBFE66666, 3'b000);
    @(negedge clk);
    check("wake_power_off_fell", fpu_power_off_add, 0);
    check("wake_enable_low", fpu_enable_add, 0);
    repeat (3) @(negedge clk);
    check("wake_enable_still_low", fpu_enable_add, 0);
    @(negedge clk);
    check("wake_enable_rose", fpu_enable_add, 1);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
